// File: rtl/uart_rx_data_sampler_if.sv
// Bundle between the UART RX bit timing logic and the data sampler.
// master: the side that drives the frame timing and the serial line.
// slave : the sampler, returning resolved bits and the received byte.
interface uart_rx_data_sampler_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4,
  parameter int DATA_W     = 8
);
  logic                  enable;
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  par_en;
  logic                  par_typ;
  logic                  sampled_bit;
  logic                  sample_done;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [DATA_W-1:0]     p_data;
  logic                  data_valid;

  modport master (
    output enable, RX_IN, prescale, edge_cnt, bit_cnt, par_en, par_typ,
    input  sampled_bit, sample_done, strt_glitch, par_err, stp_err, p_data, data_valid
  );

  modport slave (
    input  enable, RX_IN, prescale, edge_cnt, bit_cnt, par_en, par_typ,
    output sampled_bit, sample_done, strt_glitch, par_err, stp_err, p_data, data_valid
  );
endinterface

// File: rtl/uart_rx_data_sampler.sv
// UART RX data sampler: oversamples RX_IN around the middle of each bit,
// resolves one bit value per bit period, checks start/parity/stop and
// delivers the deserialised byte (LSB first).
// Optional feature: define RX_SAMPLE_MAJ_EN for a 3-sample majority vote at
// edge_cnt = mid-1, mid, mid+1; otherwise the single sample taken at mid is used.
module uart_rx_data_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4,
  parameter int DATA_W     = 8
) (
  input logic                    CLK,
  input logic                    RST,
  uart_rx_data_sampler_if.slave  bus
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_W);
  localparam logic [BIT_CNT_W-1:0] PAR_IDX   = BIT_CNT_W'(DATA_W + 1);

  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] mid_p1;
  logic [BIT_CNT_W-1:0]  stop_idx;
  logic                  resolve;
  logic                  vote;
  logic                  samp_mid;
  logic [DATA_W-1:0]     shift_reg;

  logic                  sampled_bit_r;
  logic                  sample_done_r;
  logic                  strt_glitch_r;
  logic                  par_err_r;
  logic                  stp_err_r;
  logic [DATA_W-1:0]     p_data_r;
  logic                  data_valid_r;

  assign mid      = bus.prescale >> 1;
  assign mid_p1   = mid + PRESCALE_W'(1);
  assign stop_idx = bus.par_en ? PAR_IDX + BIT_CNT_W'(1) : PAR_IDX;
  // indices past the stop bit never produce a vote
  assign resolve  = bus.enable && (bus.edge_cnt == mid_p1) && (bus.bit_cnt <= stop_idx);

`ifdef RX_SAMPLE_MAJ_EN
  logic                  samp_lo;
  logic [PRESCALE_W-1:0] mid_m1;

  assign mid_m1 = mid - PRESCALE_W'(1);

  // early sample one edge before mid; cleared whenever the frame is not running
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                        samp_lo <= 1'b0;
    else if (!bus.enable)                            samp_lo <= 1'b0;
    else if (bus.edge_cnt == mid_m1)                 samp_lo <= bus.RX_IN;
  end

  // majority of the two stored samples and the live line at mid+1
  assign vote = (samp_lo & samp_mid) | (samp_lo & bus.RX_IN) | (samp_mid & bus.RX_IN);
`else
  assign vote = samp_mid;
`endif

  // centre sample; cleared whenever the frame is not running
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                        samp_mid <= 1'b0;
    else if (!bus.enable)                            samp_mid <= 1'b0;
    else if (bus.edge_cnt == mid)                    samp_mid <= bus.RX_IN;
  end

  // per-bit resolution: shift data, check start/parity/stop, publish the byte
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_reg     <= '0;
      sampled_bit_r <= 1'b0;
      sample_done_r <= 1'b0;
      strt_glitch_r <= 1'b0;
      par_err_r     <= 1'b0;
      stp_err_r     <= 1'b0;
      p_data_r      <= '0;
      data_valid_r  <= 1'b0;
    end else begin
      sample_done_r <= 1'b0;
      strt_glitch_r <= 1'b0;
      data_valid_r  <= 1'b0;
      if (!bus.enable) begin
        shift_reg <= '0;
      end else if (resolve) begin
        sampled_bit_r <= vote;
        sample_done_r <= 1'b1;
        if (bus.bit_cnt == '0) begin
          par_err_r     <= 1'b0;
          stp_err_r     <= 1'b0;
          strt_glitch_r <= vote;
          shift_reg     <= '0;
        end else if (bus.bit_cnt <= LAST_DATA) begin
          shift_reg <= {vote, shift_reg[DATA_W-1:1]};
        end else if (bus.par_en && (bus.bit_cnt == PAR_IDX)) begin
          par_err_r <= ((^shift_reg) ^ vote) != bus.par_typ;
        end
        // parity has already been registered by the time the stop bit resolves
        if ((bus.bit_cnt == stop_idx) && (bus.bit_cnt != '0)) begin
          stp_err_r <= ~vote;
          if (vote && !par_err_r) begin
            p_data_r     <= shift_reg;
            data_valid_r <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.sampled_bit = sampled_bit_r;
  assign bus.sample_done = sample_done_r;
  assign bus.strt_glitch = strt_glitch_r;
  assign bus.par_err     = par_err_r;
  assign bus.stp_err     = stp_err_r;
  assign bus.p_data      = p_data_r;
  assign bus.data_valid  = data_valid_r;

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Scoreboard bench for uart_rx_data_sampler: the frame driver pushes the
// expected result of every bit resolution, a negedge monitor pops and compares.
module tb_uart_rx_data_sampler;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  uart_rx_data_sampler_if bus ();

  uart_rx_data_sampler dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct {
    int         bidx;
    logic       sb;
    logic       sg;
    logic       dv;
    logic       chk_end;
    logic [7:0] pd;
    logic       pe;
    logic       se;
  } exp_t;

  exp_t sbq[$];
  exp_t r;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   stray     = 0;

`ifdef RX_SAMPLE_MAJ_EN
  localparam logic       GLITCH_EXP = 1'b0;
  localparam logic [7:0] GLITCH_PD  = 8'h5A;
`else
  localparam logic       GLITCH_EXP = 1'b1;
  localparam logic [7:0] GLITCH_PD  = 8'h5B;
`endif

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act != exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  // pop one expectation per sample_done; any other pulse is stray
  always @(negedge CLK) begin
    if (bus.sample_done) begin
      if (sbq.size() == 0) begin
        stray++;
      end else begin
        r = sbq.pop_front();
        check($sformatf("sampled_bit[b%0d]", r.bidx), int'(bus.sampled_bit), int'(r.sb));
        check($sformatf("strt_glitch[b%0d]", r.bidx), int'(bus.strt_glitch), int'(r.sg));
        check($sformatf("data_valid[b%0d]", r.bidx), int'(bus.data_valid), int'(r.dv));
        if (r.chk_end) begin
          check("p_data", int'(bus.p_data), int'(r.pd));
          check("par_err", int'(bus.par_err), int'(r.pe));
          check("stp_err", int'(bus.stp_err), int'(r.se));
        end
      end
    end else if (bus.data_valid || bus.strt_glitch) begin
      stray++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    bus.enable   = 1'b0;
    bus.edge_cnt = '0;
    bus.bit_cnt  = '0;
    bus.RX_IN    = 1'b1;
    repeat (n) step();
  endtask

  // abort_kind: 0 none, 1 reset at abort_bit, 2 enable low at abort_bit
  task automatic run_frame(input int ps, input logic [7:0] data, input logic pen,
                           input logic ptyp, input logic pbit, input logic start_v,
                           input logic stop_v, input int glitch_idx, input logic glitch_exp,
                           input int abort_bit, input int abort_kind,
                           input logic [7:0] exp_pd, input logic exp_dv,
                           input logic exp_pe, input logic exp_se);
    logic bits [11];
    int   nb;
    int   mid;
    logic v;
    exp_t e_rec;
    bits[0] = start_v;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    bits[9]  = pen ? pbit : stop_v;
    bits[10] = stop_v;
    nb  = pen ? 11 : 10;
    mid = ps / 2;
    stray = 0;
    bus.prescale = 6'(ps);
    bus.par_en   = pen;
    bus.par_typ  = ptyp;
    for (int b = 0; b < nb; b++) begin
      for (int e = 0; e < ps; e++) begin
        if (abort_kind != 0 && b == abort_bit && e == 0) begin
          if (abort_kind == 1) begin
            RST = 1'b0;
            step();
            check("rst_p_data", int'(bus.p_data), 0);
            check("rst_flags", int'({bus.sampled_bit, bus.sample_done, bus.strt_glitch,
                                     bus.par_err, bus.stp_err, bus.data_valid}), 0);
            RST = 1'b1;
          end else begin
            bus.enable = 1'b0;
            for (int bb = b; bb < nb; bb++) begin
              for (int ee = 0; ee < ps; ee++) begin
                bus.bit_cnt  = 4'(bb);
                bus.edge_cnt = 6'(ee);
                bus.RX_IN    = bits[bb];
                step();
              end
            end
            check("abort_p_data", int'(bus.p_data), int'(exp_pd));
          end
          idle(3);
          check("stray_pulses", stray, 0);
          return;
        end
        bus.enable   = 1'b1;
        bus.bit_cnt  = 4'(b);
        bus.edge_cnt = 6'(e);
        v = bits[b];
        if (b == glitch_idx && e == mid) v = ~v;
        bus.RX_IN = v;
        if (e == mid + 1) begin
          e_rec.bidx    = b;
          e_rec.sb      = (b == glitch_idx) ? glitch_exp : bits[b];
          e_rec.sg      = (b == 0) ? start_v : 1'b0;
          e_rec.dv      = (b == nb - 1) ? exp_dv : 1'b0;
          e_rec.chk_end = (b == nb - 1);
          e_rec.pd      = exp_pd;
          e_rec.pe      = exp_pe;
          e_rec.se      = exp_se;
          sbq.push_back(e_rec);
        end
        step();
      end
    end
    idle(3);
    check("stray_pulses", stray, 0);
  endtask

  initial begin
    bus.enable   = 1'b0;
    bus.RX_IN    = 1'b1;
    bus.prescale = 6'd8;
    bus.edge_cnt = '0;
    bus.bit_cnt  = '0;
    bus.par_en   = 1'b0;
    bus.par_typ  = 1'b0;
    repeat (3) step();
    check("reset_p_data", int'(bus.p_data), 0);
    check("reset_flags", int'({bus.sampled_bit, bus.sample_done, bus.strt_glitch,
                               bus.par_err, bus.stp_err, bus.data_valid}), 0);
    RST = 1'b1;
    idle(2);

    // ps  data  pen ptyp pbit st sp glitch gexp abort kind exp_pd dv pe se
    run_frame(8,  8'hA5, 0, 0, 0, 0, 1, -1, 0, -1, 0, 8'hA5, 1, 0, 0);
    run_frame(16, 8'h3C, 1, 0, 0, 0, 1, -1, 0, -1, 0, 8'h3C, 1, 0, 0);
    run_frame(16, 8'h3C, 1, 0, 1, 0, 1, -1, 0, -1, 0, 8'h3C, 0, 1, 0);
    run_frame(32, 8'hC3, 1, 1, 1, 0, 1, -1, 0, -1, 0, 8'hC3, 1, 0, 0);
    run_frame(8,  8'h5A, 0, 0, 0, 0, 1, 1, GLITCH_EXP, -1, 0, GLITCH_PD, 1, 0, 0);
    run_frame(8,  8'h00, 0, 0, 0, 1, 0, -1, 0, -1, 0, GLITCH_PD, 0, 0, 1);
    run_frame(8,  8'hFF, 0, 0, 0, 0, 1, -1, 0, 5, 1, 8'h00, 0, 0, 0);
    run_frame(8,  8'h81, 0, 0, 0, 0, 1, -1, 0, -1, 0, 8'h81, 1, 0, 0);
    run_frame(8,  8'hA5, 0, 0, 0, 0, 1, -1, 0, -1, 0, 8'hA5, 1, 0, 0);
    run_frame(8,  8'h3C, 0, 0, 0, 0, 1, -1, 0, 4, 2, 8'hA5, 0, 0, 0);
    run_frame(8,  8'h42, 0, 0, 0, 0, 1, -1, 0, -1, 0, 8'h42, 1, 0, 0);

    idle(2);
    check("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
